// File: rtl/pc_next_ctrl_pkg.sv
// Shared definitions for the next-PC controller: state encodings, default
// reset vector and the combinational branch/jump target selection.
package pc_next_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_BOOT   = 3'd0,
    ST_RUN    = 3'd1,
    ST_PAUSE  = 3'd2,
    ST_HALTED = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

  // Priority: jr over jump over taken branch over sequential; imm_ext is in words.
  function automatic logic [31:0] calc_target(
    input logic [31:0] pc1,
    input logic        branch,
    input logic        zero,
    input logic        jump,
    input logic        jr,
    input logic [31:0] imm_ext,
    input logic [25:0] jaddr,
    input logic [31:0] rs_val
  );
    logic [31:0] pc4;
    pc4 = pc1 + 32'd4;
    if (jr)                  calc_target = rs_val;
    else if (jump)           calc_target = {pc4[31:28], jaddr, 2'b00};
    else if (branch && zero) calc_target = pc4 + (imm_ext << 2);
    else                     calc_target = pc4;
  endfunction

endpackage

// File: rtl/pc_next_ctrl_step_debounce.sv
// Push-button step input: 2-FF synchroniser, debounce down-counter and
// one-shot pulse that re-arms only after the synchronised level drops.
module step_debounce #(
  parameter int STEP_DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int CW = (STEP_DEBOUNCE > 1) ? $clog2(STEP_DEBOUNCE) : 1;
  localparam logic [CW-1:0] LOAD = CW'(STEP_DEBOUNCE - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fired_q, fired_d;

  // Counter reaches zero on the STEP_DEBOUNCE-th consecutive high cycle.
  assign pulse = sync2_q && (cnt_q == '0) && !fired_q;

  always_comb begin
    cnt_d   = cnt_q;
    fired_d = fired_q;
    if (!sync2_q) begin
      cnt_d   = LOAD;
      fired_d = 1'b0;
    end else begin
      if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      if (pulse)       fired_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= LOAD;
      fired_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      fired_q <= fired_d;
    end
  end

endmodule

// File: rtl/pc_next_ctrl.sv
// Next-PC stage with run control (free-run, pause/step, halt, fault); the
// downstream PC register has no reset/enable, so holding means newpc1 = pc1.
//
//   state  | meaning
//   BOOT   | one cycle after reset, PC loads RESET_VEC
//   RUN    | advance every cycle
//   PAUSE  | advance only on a debounced step pulse
//   HALTED | HALT retired, PC frozen until reset
//   FAULT  | misaligned JR, PC frozen until reset
module pc_next_ctrl
  import pc_next_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VEC     = DEFAULT_RESET_VEC,
  parameter int          STEP_DEBOUNCE = 4,
  parameter int          CNT_W         = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        pc1,
  input  logic               branch,
  input  logic               zero,
  input  logic               jump,
  input  logic               jr,
  input  logic [31:0]        imm_ext,
  input  logic [25:0]        jaddr,
  input  logic [31:0]        rs_val,
  input  logic               halt_instr,
  input  logic               run_mode,
  input  logic               step_btn,
  output logic [31:0]        newpc1,
  output logic [STATE_W-1:0] state,
  output logic               halted,
  output logic [CNT_W-1:0]   retire_cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic [31:0]      pc_d;
  logic [31:0]      target;
  logic             step_pulse;
  logic             advance;

  step_debounce #(
    .STEP_DEBOUNCE(STEP_DEBOUNCE)
  ) u_step (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (step_btn),
    .pulse(step_pulse)
  );

  assign target = calc_target(pc1, branch, zero, jump, jr, imm_ext, jaddr, rs_val);

  always_comb begin
    state_d  = state_q;
    retire_d = retire_q;
    pc_d     = pc1;
    advance  = 1'b0;

    case (state_q)
      ST_BOOT: begin
        pc_d    = RESET_VEC;
        state_d = run_mode ? ST_RUN : ST_PAUSE;
      end
      ST_RUN: begin
        advance = 1'b1;
        if (!run_mode) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        advance = step_pulse;
        if (run_mode) state_d = ST_RUN;
      end
      ST_HALTED, ST_FAULT: ;
      default: state_d = ST_FAULT;
    endcase

    // Halt/fault override any run_mode transition chosen above.
    if (advance) begin
      if (halt_instr) begin
        retire_d = retire_q + CNT_W'(1);
        state_d  = ST_HALTED;
      end else if (jr && (rs_val[1:0] != 2'b00)) begin
        state_d  = ST_FAULT;
      end else begin
        pc_d     = target;
        retire_d = retire_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_BOOT;
      retire_q <= '0;
    end else begin
      state_q  <= state_d;
      retire_q <= retire_d;
    end
  end

  assign newpc1     = rst_n ? pc_d : RESET_VEC;
  assign state      = state_q;
  assign halted     = (state_q == ST_HALTED) || (state_q == ST_FAULT);
  assign retire_cnt = retire_q;

endmodule
